icache_dm: RTL

//  Direct-mapped, read-only instruction cache between the fetch stage and the external instruction bus.

---
 rtl/icache_pkg.sv | 34 +++
 rtl/icache_data_ram.sv | 34 +++
 rtl/icache_dm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared state encoding, default geometry and address-field
//               width helpers for the direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // The two byte-offset bits are never part of the tag.
    function automatic int tag_w(input int line_words, input int num_lines);
        return 30 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : icache_data_ram
// Description : Synchronous 1R1W word array holding the cached instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int DEPTH  = DEF_LINE_WORDS * DEF_NUM_LINES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped read-only instruction cache with burst line
//               refill. Define ICACHE_PERF_CNT_EN to add hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        req_valid_i,
    input  logic        jump_stop_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(LINE_WORDS, NUM_LINES);
    localparam logic [OFF_W-1:0] c_last_beat = OFF_W'(LINE_WORDS - 1);

    state_t             r_state, w_state_nx;
    logic [TAG_W-1:0]   r_tag_mem [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]   r_req_tag;
    logic [IDX_W-1:0]   r_req_idx;
    logic [OFF_W-1:0]   r_req_off;
    logic [OFF_W-1:0]   r_beat;
    logic [31:0]        r_miss_word;
    logic               r_abort;
    logic               r_hit_q;

    logic [OFF_W-1:0]   w_pc_off;
    logic [IDX_W-1:0]   w_pc_idx;
    logic [TAG_W-1:0]   w_pc_tag;
    logic               w_hit, w_accept, w_beat, w_last_beat;
    logic [31:0]        w_ram_rdata;
    logic               w_unused;

    assign w_pc_off    = pc_i[OFF_W+1:2];
    assign w_pc_idx    = pc_i[OFF_W+2 +: IDX_W];
    assign w_pc_tag    = pc_i[31 -: TAG_W];
    assign w_unused    = &{1'b0, pc_i[1:0]};
    assign w_hit       = r_valid[w_pc_idx] && (r_tag_mem[w_pc_idx] == w_pc_tag);
    assign w_accept    = (r_state == ST_IDLE) && req_valid_i;
    assign w_beat      = (r_state == ST_FILL) && mem_rvalid_i;
    assign w_last_beat = w_beat && (r_beat == c_last_beat);

    icache_data_ram #(
        .DEPTH  (NUM_LINES * LINE_WORDS),
        .ADDR_W (IDX_W + OFF_W)
    ) u_data_ram (
        .clk     (clk),
        .rd_en   (w_accept),
        .rd_addr ({w_pc_idx, w_pc_off}),
        .rd_data (w_ram_rdata),
        .wr_en   (w_beat),
        .wr_addr ({r_req_idx, r_beat}),
        .wr_data (mem_rdata_i)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_hit) w_state_nx = ST_REQ;
            ST_REQ:  if (mem_ready_i)        w_state_nx = ST_FILL;
            ST_FILL: if (w_last_beat)        w_state_nx = ST_DONE;
            ST_DONE:                         w_state_nx = ST_IDLE;
            default:                         w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_req_tag   <= '0;
            r_req_idx   <= '0;
            r_req_off   <= '0;
            r_beat      <= '0;
            r_miss_word <= '0;
            r_abort     <= 1'b0;
            r_hit_q     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_hit_q <= w_accept && w_hit;
            if (w_accept) begin
                r_req_tag <= w_pc_tag;
                r_req_idx <= w_pc_idx;
                r_req_off <= w_pc_off;
            end
            if (r_state == ST_REQ) begin
                r_beat <= '0;
            end else if (w_beat) begin
                r_beat <= r_beat + 1'b1;
                // The requested word is captured in flight so DONE needs no RAM read.
                if (r_beat == r_req_off) begin
                    r_miss_word <= mem_rdata_i;
                end
            end
            if (w_last_beat) begin
                r_valid[r_req_idx] <= 1'b1;
            end
            if (((r_state == ST_REQ) || (r_state == ST_FILL)) && jump_stop_i) begin
                r_abort <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_abort <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_tag_mem[r_req_idx] <= r_req_tag;
        end
    end

    always_comb begin
        stall_o      = (r_state == ST_REQ) || (r_state == ST_FILL);
        mem_req_o    = (r_state == ST_REQ);
        mem_addr_o   = '0;
        inst_valid_o = r_hit_q || ((r_state == ST_DONE) && !r_abort);
        inst_o       = '0;
        if (r_state == ST_REQ) begin
            mem_addr_o = {r_req_tag, r_req_idx, {(OFF_W + 2){1'b0}}};
        end
        if (r_hit_q) begin
            inst_o = w_ram_rdata;
        end else if ((r_state == ST_DONE) && !r_abort) begin
            inst_o = r_miss_word;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (w_accept) begin
            if (w_hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else       miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
